// File: rtl/dc_pkg.sv
// Shared types for the dclib decoupled flow-control stages.
// Holds the stage occupancy enum and the default payload width.
package dc_pkg;

    typedef enum logic [1:0] {
        DC_EMPTY = 2'd0,
        DC_ONE   = 2'd1,
        DC_TWO   = 2'd2
    } dc_state_e;

    localparam int DC_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/dc_input_stage.sv
// Decoupled input stage: main + skid buffer, all outputs from flops.
// Ports: clock, reset (sync, high), io_enq_* upstream, io_deq_* downstream.
// Option: DC_INPUT_STAGE_ASSERT_EN compiles in immediate assertions.
module dc_input_stage
    import dc_pkg::*;
#(
    parameter int WIDTH = DC_DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_enq_valid,
    output logic             io_enq_ready,
    input  logic [WIDTH-1:0] io_enq_bits,
    output logic             io_deq_valid,
    input  logic             io_deq_ready,
    output logic [WIDTH-1:0] io_deq_bits
);

    dc_state_e        state_q;
    dc_state_e        next_state;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic             ready_r;
    logic             enq_fire;
    logic             deq_fire;

    assign io_enq_ready = ready_r;
    assign io_deq_valid = (state_q != DC_EMPTY);
    assign io_deq_bits  = main_q;

    assign enq_fire = io_enq_valid & ready_r;
    assign deq_fire = io_deq_valid & io_deq_ready;

    always_comb begin
        next_state = state_q;
        main_d     = main_q;
        skid_d     = skid_q;
        unique case (state_q)
            DC_EMPTY: begin
                if (enq_fire) begin
                    main_d     = io_enq_bits;
                    next_state = DC_ONE;
                end
            end
            DC_ONE: begin
                if (enq_fire && deq_fire) begin
                    main_d = io_enq_bits;
                end else if (enq_fire) begin
                    skid_d     = io_enq_bits;
                    next_state = DC_TWO;
                end else if (deq_fire) begin
                    next_state = DC_EMPTY;
                end
            end
            DC_TWO: begin
                // ready_r is low here, so only the drain path exists
                if (deq_fire) begin
                    main_d     = skid_q;
                    next_state = DC_ONE;
                end
            end
            default: begin
                next_state = DC_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DC_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_r <= 1'b0;
        end else begin
            state_q <= next_state;
            main_q  <= main_d;
            skid_q  <= skid_d;
            // registered from next state so ready never depends on deq_ready
            ready_r <= (next_state != DC_TWO);
        end
    end

`ifdef DC_INPUT_STAGE_ASSERT_EN
    logic             seen_q;
    logic             stall_q;
    logic [WIDTH-1:0] bits_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            seen_q  <= 1'b0;
            stall_q <= 1'b0;
            bits_q  <= '0;
        end else begin
            seen_q  <= 1'b1;
            stall_q <= io_deq_valid & ~io_deq_ready;
            bits_q  <= io_deq_bits;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            a_state_enc: assert (state_q inside {DC_EMPTY, DC_ONE, DC_TWO});
            a_deq_valid: assert (io_deq_valid == (state_q != DC_EMPTY));
            // first post-reset cycle still shows the reset value of ready_r
            if (seen_q) begin
                a_enq_ready: assert (io_enq_ready == (state_q != DC_TWO));
            end
            if (stall_q) begin
                a_stable: assert (io_deq_bits == bits_q);
            end
        end
    end
`endif

endmodule
